audio_playback_ctrl: RTL and testbench
======================================

Name: audio_playback_ctrl

Overview:
- Sequences mono PCM playback from an on-chip sample ROM into the audio codec's I2S serial-data input.
- The codec is I2S master and supplies bit and frame clocks on Arduino header pins, so this block is an I2S slave transmitter.
- Runs in the 50 MHz system clock domain alongside color_mapper and Character_Movement.
- Game logic issues play and stop requests; the block fetches one sample per frame and drives the same sample on both channels.

Parameters:
- SAMPLE_W, 16, bits per sample and per I2S word.
- ADDR_W, 16, sample ROM address width.
- ROM_LAT, 2, cycles from rom_addr change to valid rom_data (range 1 to 4).

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-high.
- SClk  in  1  codec bit clock; asynchronous to Clk.
- LRClk  in  1  codec word clock; 0 = left, 1 = right; asynchronous to Clk.
- play  in  1  single-cycle start request.
- stop  in  1  single-cycle abort request.
- loop  in  1  restart at base_addr after the last sample.
- mute  in  1  forces transmitted words to 0.
- base_addr  in  ADDR_W  first sample address; captured on play.
- length  in  ADDR_W  sample count; captured on play.
- rom_addr  out  ADDR_W  sample ROM address.
- rom_data  in  SAMPLE_W  sample ROM data.
- sd  out  1  I2S serial data to codec.
- playing  out  1  high from accepted play until IDLE.
- done  out  1  one-cycle pulse on natural end of playback.

Behaviour:
- Reset: every register is 0, including sd, rom_addr, playing, done, the sample registers, the shift register and the LR history. State is IDLE.
- Synchronisers: SClk and LRClk each pass through 2 flops, plus 1 history flop. This yields sclk_rise and sclk_fall single-cycle strobes. Functional requirement on the environment: SClk high and low phases are each at least 3 Clk cycles.
- LR edge detection: on sclk_rise, lr_r <= synchronised LRClk.
  - If the sampled value differs from the previous lr_r, set load_pending.
  - A 1->0 change is a left boundary.
- Serialiser, acting on sclk_fall only:
  - If load_pending: sd <= word[MSB], shift register <= word shifted left by 1, bit counter <= SAMPLE_W-1, clear load_pending.
  - Else if bit counter is non-zero: sd <= next bit, decrement the counter.
  - Else: sd <= 0.
  - This places the MSB one SClk after the LR transition, per I2S. Bits after the LSB are zero.
- Word value: word = mute ? 0 : cur_sample. It is the same for left and right. mute takes effect at the next word load.
- FSM states: IDLE, FETCH, WAIT, TAIL.
  - IDLE: cur_sample = 0.
    - play with length != 0: ptr <= base_addr, remaining <= length, playing <= 1, go to FETCH.
    - play with length == 0: ignored.
  - FETCH: rom_addr = ptr; wait ROM_LAT cycles.
    - Then next_sample <= rom_data, ptr <= ptr+1 (wraps mod 2^ADDR_W), remaining <= remaining-1.
    - last <= (remaining == 1). Go to WAIT.
  - WAIT: at a left boundary, cur_sample <= next_sample.
    - If last and loop: ptr <= base, remaining <= length, go to FETCH.
    - If last and not loop: go to TAIL.
    - Otherwise: go to FETCH.
  - TAIL: at the next left boundary, cur_sample <= 0, done <= 1 for 1 cycle, playing <= 0, go to IDLE.
- Output before the first boundary after play is silence (cur_sample = 0).
- A fetch completes in ROM_LAT+1 cycles, far less than the frame period of about 1041 cycles, so underrun is impossible.
- stop: in any state, the next cycle gives IDLE, playing = 0, cur_sample = 0, and no done.
  - A word already being shifted completes unchanged.
  - stop has priority over a simultaneous play.
- play while playing: restarts from the new base_addr/length via FETCH; no done for the aborted run.
- Reset asserted mid-word: sd drops to 0 immediately.

Test Plan:
- Reset with SClk/LRClk toggling -> sd=0, playing=0, done=0, rom_addr=0 throughout.
- ROM[0x10]=0xA5C3, ROM[0x11]=0x8001; play with base 0x0010, length 2; SClk=64fs -> after silence, first frame left and right both carry 0xA5C3. MSB is on the 1st SClk fall after the LR edge, followed by 15 data bits and 16 zeros. Second frame carries 0x8001.
- Same run, continued -> frame 3 is all zeros, done pulses exactly 1 cycle at the left boundary starting frame 3, playing falls that cycle, and no further done.
- loop=1, base 0x0010, length 3 -> rom_addr sequence 0x10, 0x11, 0x12, 0x10, 0x11; playing stays 1 and done never pulses.
- stop asserted mid-left word of 0xA5C3 -> that word completes, following words are 0, playing=0 one cycle after stop, no done. play and stop in the same cycle -> stays IDLE.
- play with length=0 -> no state change. play with base 0xFFFF, length 2 -> rom_addr 0xFFFF then 0x0000. mute=1 during playback -> next loaded word is 0x0000 and sequencing continues.

Source files
------------

// File: rtl/audio_playback_ctrl.sv
// audio_playback_ctrl: sequences mono PCM samples from a sample ROM into an
// I2S slave transmitter. The codec supplies SClk/LRClk (asynchronous to Clk);
// one sample is fetched per frame and sent on both the left and right channels.
module audio_playback_ctrl #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 16,
  parameter int ROM_LAT  = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                SClk,
  input  logic                LRClk,
  input  logic                play,
  input  logic                stop,
  input  logic                loop,
  input  logic                mute,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic                sd,
  output logic                playing,
  output logic                done
);

  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam logic [ADDR_W-1:0]   ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]   ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [SAMPLE_W-1:0] SMP_ZERO  = {SAMPLE_W{1'b0}};
  localparam logic [2:0]          LAT_LAST  = 3'(ROM_LAT);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_TAIL} state_t;

  // Synchroniser and edge-detect flops for the codec clocks
  logic r_sclk_s1, r_sclk_s2, r_sclk_h;
  logic r_lr_s1, r_lr_s2;
  // LR history, pending word load and serialiser state
  logic                r_lr;
  logic                r_load_pend;
  logic                r_sd;
  logic [SAMPLE_W-1:0] r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  // Sequencer registers
  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr, r_remaining, r_base, r_len, r_rom_addr;
  logic [2:0]          r_lat_cnt;
  logic [SAMPLE_W-1:0] r_next_sample, r_cur_sample;
  logic                r_last, r_playing, r_done;
  // Next-state values
  state_t              w_state_nx;
  logic [ADDR_W-1:0]   w_ptr_nx, w_remaining_nx, w_base_nx, w_len_nx, w_rom_addr_nx;
  logic [2:0]          w_lat_cnt_nx;
  logic [SAMPLE_W-1:0] w_next_sample_nx, w_cur_sample_nx;
  logic                w_last_nx, w_playing_nx, w_done_nx;
  // Strobes and datapath helpers
  logic                w_sclk_rise, w_sclk_fall, w_left_bnd, w_start;
  logic [SAMPLE_W-1:0] w_word;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_h;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_h;
  // A 1->0 LR change seen at an SClk rise marks the start of a frame (left word)
  assign w_left_bnd  = w_sclk_rise & r_lr & ~r_lr_s2;
  assign w_start     = play & (length != ADDR_ZERO);
  assign w_word      = mute ? SMP_ZERO : r_cur_sample;

  assign rom_addr = r_rom_addr;
  assign sd       = r_sd;
  assign playing  = r_playing;
  assign done     = r_done;

  // Bring SClk and LRClk into the Clk domain and keep SClk history for edges
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_h  <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
    end else begin
      r_sclk_s1 <= SClk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_h  <= r_sclk_s2;
      r_lr_s1   <= LRClk;
      r_lr_s2   <= r_lr_s1;
    end
  end

  // Track LR on SClk rises and shift words out MSB-first on SClk falls
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_lr        <= 1'b0;
      r_load_pend <= 1'b0;
      r_sd        <= 1'b0;
      r_shift     <= SMP_ZERO;
      r_bit_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (w_sclk_rise) begin
        r_lr <= r_lr_s2;
        if (r_lr_s2 != r_lr) begin
          r_load_pend <= 1'b1;
        end
      end
      if (w_sclk_fall) begin
        if (r_load_pend) begin
          r_sd        <= w_word[SAMPLE_W-1];
          r_shift     <= {w_word[SAMPLE_W-2:0], 1'b0};
          r_bit_cnt   <= CNT_W'(SAMPLE_W - 1);
          r_load_pend <= 1'b0;
        end else if (r_bit_cnt != {CNT_W{1'b0}}) begin
          r_sd      <= r_shift[SAMPLE_W-1];
          r_shift   <= {r_shift[SAMPLE_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          r_sd <= 1'b0;
        end
      end
    end
  end

  // Sequencer next-state: stop beats play, play restarts, else per-state work
  always_comb begin
    w_state_nx       = r_state;
    w_ptr_nx         = r_ptr;
    w_remaining_nx   = r_remaining;
    w_base_nx        = r_base;
    w_len_nx         = r_len;
    w_lat_cnt_nx     = r_lat_cnt;
    w_next_sample_nx = r_next_sample;
    w_cur_sample_nx  = r_cur_sample;
    w_last_nx        = r_last;
    w_playing_nx     = r_playing;
    w_done_nx        = 1'b0;
    if (stop) begin
      w_state_nx      = S_IDLE;
      w_playing_nx    = 1'b0;
      w_cur_sample_nx = SMP_ZERO;
    end else if (w_start) begin
      w_state_nx     = S_FETCH;
      w_base_nx      = base_addr;
      w_len_nx       = length;
      w_ptr_nx       = base_addr;
      w_remaining_nx = length;
      w_lat_cnt_nx   = 3'd0;
      w_playing_nx   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cur_sample_nx = SMP_ZERO;
        end
        S_FETCH: begin
          if (r_lat_cnt == LAT_LAST) begin
            w_next_sample_nx = rom_data;
            w_ptr_nx         = r_ptr + ADDR_ONE;
            w_remaining_nx   = r_remaining - ADDR_ONE;
            w_last_nx        = (r_remaining == ADDR_ONE);
            w_lat_cnt_nx     = 3'd0;
            w_state_nx       = S_WAIT;
          end else begin
            w_lat_cnt_nx = r_lat_cnt + 3'd1;
          end
        end
        S_WAIT: begin
          if (w_left_bnd) begin
            w_cur_sample_nx = r_next_sample;
            if (r_last) begin
              if (loop) begin
                w_ptr_nx       = r_base;
                w_remaining_nx = r_len;
                w_state_nx     = S_FETCH;
              end else begin
                w_state_nx = S_TAIL;
              end
            end else begin
              w_state_nx = S_FETCH;
            end
          end else begin
            w_state_nx = S_WAIT;
          end
        end
        S_TAIL: begin
          if (w_left_bnd) begin
            w_cur_sample_nx = SMP_ZERO;
            w_done_nx       = 1'b1;
            w_playing_nx    = 1'b0;
            w_state_nx      = S_IDLE;
          end else begin
            w_state_nx = S_TAIL;
          end
        end
        default: begin
          w_state_nx      = S_IDLE;
          w_playing_nx    = 1'b0;
          w_cur_sample_nx = SMP_ZERO;
        end
      endcase
    end
    // The ROM address follows the pointer whenever a fetch is (or stays) active
    if (w_state_nx == S_FETCH) begin
      w_rom_addr_nx = w_ptr_nx;
    end else begin
      w_rom_addr_nx = r_rom_addr;
    end
  end

  // Sequencer state and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= ADDR_ZERO;
      r_remaining   <= ADDR_ZERO;
      r_base        <= ADDR_ZERO;
      r_len         <= ADDR_ZERO;
      r_rom_addr    <= ADDR_ZERO;
      r_lat_cnt     <= 3'd0;
      r_next_sample <= SMP_ZERO;
      r_cur_sample  <= SMP_ZERO;
      r_last        <= 1'b0;
      r_playing     <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_ptr         <= w_ptr_nx;
      r_remaining   <= w_remaining_nx;
      r_base        <= w_base_nx;
      r_len         <= w_len_nx;
      r_rom_addr    <= w_rom_addr_nx;
      r_lat_cnt     <= w_lat_cnt_nx;
      r_next_sample <= w_next_sample_nx;
      r_cur_sample  <= w_cur_sample_nx;
      r_last        <= w_last_nx;
      r_playing     <= w_playing_nx;
      r_done        <= w_done_nx;
    end
  end

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Bench for audio_playback_ctrl: drives codec-style SClk/LRClk (64 fs), keeps a
// frame-level reference model, and checks serial words, ROM addresses, playing
// and done through scoreboard queues drained by independent monitors.
`timescale 1ns/1ps
module tb_audio_playback_ctrl;

  localparam int HALF = 57;   // SClk half period in ns (Clk period is 10 ns)
  localparam int A_NONE = 0, A_PLAY = 1, A_STOP = 2, A_PLAYSTOP = 3, A_MUTE_ON = 4, A_MUTE_OFF = 5;

  logic        Clk = 1'b0, Reset = 1'b1, SClk = 1'b1, LRClk = 1'b1;
  logic        play = 1'b0, stop = 1'b0, loop = 1'b0, mute = 1'b0;
  logic [15:0] base_addr = 16'h0, length = 16'h0;
  logic [15:0] rom_addr, rom_data;
  logic        sd, playing, done;

  audio_playback_ctrl #(.SAMPLE_W(16), .ADDR_W(16), .ROM_LAT(2)) dut (
    .Clk(Clk), .Reset(Reset), .SClk(SClk), .LRClk(LRClk), .play(play), .stop(stop),
    .loop(loop), .mute(mute), .base_addr(base_addr), .length(length),
    .rom_addr(rom_addr), .rom_data(rom_data), .sd(sd), .playing(playing), .done(done));

  always #5 Clk = ~Clk;

  // Sample ROM with a two-cycle read pipeline
  logic [15:0] mem [0:65535];
  logic [15:0] rd1, rd2;
  always @(posedge Clk) begin
    rd1 <= mem[rom_addr];
    rd2 <= rd1;
  end
  assign rom_data = rd2;

  int n_cmp = 0, n_err = 0;
  logic [15:0] exp_word_q[$];
  logic [15:0] exp_addr_q[$];
  bit   mon_en = 1'b0;
  int   done_cnt = 0;

  // Reference model (frame granularity)
  bit          m_playing = 1'b0, m_tail = 1'b0;
  logic [15:0] m_base = 16'h0, m_cur = 16'h0, m_last_addr = 16'h0;
  int          m_len = 0, m_idx = 0, m_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_addr(input logic [15:0] a);
    exp_addr_q.push_back(a);
    m_last_addr = a;
  endtask

  // Frame start: advance the model by one sample and queue the left word
  task automatic model_frame_start();
    if (m_tail) begin
      m_tail = 1'b0; m_playing = 1'b0; m_cur = 16'h0; m_done++;
    end else if (m_playing) begin
      m_cur = mem[16'(m_base + m_idx)];
      m_idx++;
      if (m_idx == m_len) begin
        if (loop) begin m_idx = 0; push_addr(m_base); end
        else m_tail = 1'b1;
      end else begin
        push_addr(16'(m_base + m_idx));
      end
    end else begin
      m_cur = 16'h0;
    end
    exp_word_q.push_back(mute ? 16'h0 : m_cur);
  endtask

  task automatic sbit(input logic lr);
    SClk = 1'b0; LRClk = lr; #HALF;
    SClk = 1'b1; #HALF;
  endtask

  task automatic do_play(input logic [15:0] b, input logic [15:0] len, input logic lp);
    @(negedge Clk);
    loop = lp; base_addr = b; length = len;
    if (len != 16'h0) begin
      m_playing = 1'b1; m_tail = 1'b0; m_base = b; m_len = int'(len); m_idx = 0;
      push_addr(b);
    end
    play = 1'b1;
    @(negedge Clk);
    play = 1'b0;
  endtask

  task automatic do_stop(input bit with_play);
    @(negedge Clk);
    stop = 1'b1; play = with_play; base_addr = 16'h0050; length = 16'h0003;
    m_playing = 1'b0; m_tail = 1'b0; m_cur = 16'h0;
    @(negedge Clk);
    stop = 1'b0; play = 1'b0;
    check("stop_playing", {31'h0, playing}, 32'h0);
  endtask

  // One 64-bit frame: left word, right word, with an action late in the right word
  task automatic frame(input int act, input logic [15:0] b, input logic [15:0] len,
                       input logic lp, input bit stop_left);
    model_frame_start();
    for (int i = 0; i < 32; i++) begin
      if (i == 4) begin
        check("playing", {31'h0, playing}, {31'h0, m_playing});
        check("done_count", done_cnt, m_done);
      end
      if (i == 8 && stop_left) do_stop(1'b0);
      sbit(1'b0);
    end
    exp_word_q.push_back(mute ? 16'h0 : m_cur);
    for (int i = 0; i < 32; i++) begin
      if (i == 24) begin
        case (act)
          A_PLAY:     do_play(b, len, lp);
          A_STOP:     do_stop(1'b0);
          A_PLAYSTOP: do_stop(1'b1);
          A_MUTE_ON:  begin @(negedge Clk); mute = 1'b1; end
          A_MUTE_OFF: begin @(negedge Clk); mute = 1'b0; end
          default:    ;
        endcase
      end
      sbit(1'b1);
    end
  endtask

  // Word monitor: behaves like the codec, sampling sd on SClk rises
  logic [30:0] acc;
  logic        prev_lr = 1'b1;
  bit          started = 1'b0;
  always @(posedge SClk) begin
    if (!mon_en) begin
      started = 1'b0;
    end else if (LRClk != prev_lr) begin
      if (started) begin
        if (exp_word_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sd_word: got %h with no expected word queued", {acc, sd});
        end else begin
          logic [15:0] e;
          e = exp_word_q.pop_front();
          check("sd_word", {acc, sd}, {e, 16'h0});
        end
      end
      started = 1'b1;
      acc = 31'h0;
    end else begin
      acc = {acc[29:0], sd};
    end
    prev_lr = LRClk;
  end

  // ROM address monitor: each new address must be the next expected fetch
  logic [15:0] seen_addr = 16'h0;
  always @(negedge Clk) begin
    if (mon_en && rom_addr != seen_addr) begin
      if (exp_addr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rom_addr: got %h with no expected address queued", rom_addr);
      end else begin
        logic [15:0] e;
        e = exp_addr_q.pop_front();
        check("rom_addr", {16'h0, rom_addr}, {16'h0, e});
      end
    end
    seen_addr = rom_addr;
  end

  // done monitor: single-cycle pulses, with playing already low
  logic done_prev = 1'b0;
  always @(negedge Clk) begin
    if (done) begin
      done_cnt++;
      check("done_playing_low", {31'h0, playing}, 32'h0);
      check("done_width", {31'h0, done_prev}, 32'h0);
    end
    done_prev = done;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0010] = 16'hA5C3; mem[16'h0011] = 16'h8001; mem[16'h0012] = 16'h3C5A;
    mem[16'hFFFF] = 16'h1234; mem[16'h0000] = 16'h5678; mem[16'h0030] = 16'hFFFF;

    // Reset held while the codec clocks run
    for (int i = 0; i < 8; i++) begin
      sbit((i < 4) ? 1'b0 : 1'b1);
      check("reset_outs", {13'h0, sd, playing, done, rom_addr}, 32'h0);
    end
    @(negedge Clk); Reset = 1'b0;
    for (int i = 0; i < 4; i++) sbit(1'b1);
    mon_en = 1'b1;

    // Two-sample run, then silence with a single done
    frame(A_PLAY, 16'h0010, 16'd2, 1'b0, 1'b0);
    repeat (4) frame(A_NONE, 16'h0, 16'h0, 1'b0, 1'b0);
    // Looping run of three, stopped after wrapping
    frame(A_PLAY, 16'h0010, 16'd3, 1'b1, 1'b0);
    repeat (3) frame(A_NONE, 16'h0, 16'h0, 1'b0, 1'b0);
    frame(A_STOP, 16'h0, 16'h0, 1'b0, 1'b0);
    frame(A_NONE, 16'h0, 16'h0, 1'b0, 1'b0);
    // Stop in the middle of a left word; play+stop together; zero length
    frame(A_PLAY, 16'h0010, 16'd2, 1'b0, 1'b0);
    frame(A_PLAYSTOP, 16'h0, 16'h0, 1'b0, 1'b1);
    frame(A_PLAY, 16'h0040, 16'd0, 1'b0, 1'b0);
    // Address wrap at the top of the ROM
    frame(A_PLAY, 16'hFFFF, 16'd2, 1'b0, 1'b0);
    repeat (3) frame(A_NONE, 16'h0, 16'h0, 1'b0, 1'b0);
    // Mute mid-run
    frame(A_PLAY, 16'h0020, 16'd4, 1'b0, 1'b0);
    frame(A_MUTE_ON, 16'h0, 16'h0, 1'b0, 1'b0);
    frame(A_NONE, 16'h0, 16'h0, 1'b0, 1'b0);
    frame(A_MUTE_OFF, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) frame(A_NONE, 16'h0, 16'h0, 1'b0, 1'b0);

    // Randomised runs, restarts, stops and mute toggles
    for (int f = 0; f < 16; f++) begin
      int sel;
      logic [15:0] b, len;
      logic lp;
      sel = int'($urandom_range(0, 9));
      len = 16'($urandom_range(0, 4));
      lp  = (len >= 16'd2) ? 1'($urandom_range(0, 1)) : 1'b0;
      b   = 16'($urandom);
      if (b == m_last_addr) b = b + 16'd7;
      if (sel <= 3)      frame(A_PLAY, b, len, lp, 1'b0);
      else if (sel == 4) frame(A_STOP, b, len, lp, 1'b0);
      else if (sel == 5) frame(mute ? A_MUTE_OFF : A_MUTE_ON, b, len, lp, 1'b0);
      else if (sel == 6) frame(A_NONE, b, len, lp, 1'b1);
      else               frame(A_NONE, b, len, lp, 1'b0);
    end
    mute = 1'b0;
    frame(A_STOP, 16'h0, 16'h0, 1'b0, 1'b0);
    frame(A_NONE, 16'h0, 16'h0, 1'b0, 1'b0);
    sbit(1'b0); sbit(1'b0);
    check("word_queue_drained", exp_word_q.size(), 32'h0);
    check("addr_queue_drained", exp_addr_q.size(), 32'h0);
    check("final_done_count", done_cnt, m_done);

    // Reset in the middle of an all-ones word drops sd at once
    mon_en = 1'b0;
    @(negedge Clk); base_addr = 16'h0030; length = 16'd1; loop = 1'b0; play = 1'b1;
    @(negedge Clk); play = 1'b0;
    for (int i = 0; i < 32; i++) sbit(1'b1);
    for (int i = 0; i < 6; i++) sbit(1'b0);
    check("midword_sd_high", {31'h0, sd}, 32'h1);
    Reset = 1'b1;
    #1;
    check("reset_sd_drop", {31'h0, sd}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
